// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial frame transmitter (preamble, data MSB first, optional even parity, idle gap).
// Latency: word accepted at edge T drives the first preamble bit on out during cycle T+1. All outputs except in_ready are registered.
// Backpressure: single entry with no buffering. in_ready stays low from accept until the frame and its gap finish, and in_valid is ignored meanwhile.
// Build option: define SEQ_TX_PARITY_EN to add the PAR state, which appends an even parity bit after the data.
module seq_pattern_tx #(
  parameter int                 PRE_LEN  = 4,
  parameter logic [PRE_LEN-1:0] PREAMBLE = 4'b0101,
  parameter int                 DATA_W   = 8,
  parameter int                 GAP      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out,
  output logic              out_en,
  output logic              busy,
  output logic              frame_done
);

  // Counter reload values. The counter holds the number of bits/cycles still to go after the current one.
  localparam logic [5:0] PRE_TOP  = 6'(PRE_LEN - 1);
  localparam logic [5:0] DATA_TOP = 6'(DATA_W - 1);
  localparam logic [5:0] GAP_TOP  = (GAP > 0) ? 6'(GAP - 1) : 6'd0;
  // The preamble is padded to 8 bits so that it can be indexed with the low 3 counter bits.
  localparam logic [7:0] PRE_PAD  = 8'(PREAMBLE);

`ifdef SEQ_TX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_DATA, ST_PAR, ST_GAP} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_DATA, ST_GAP} state_t;
`endif

  state_t            state, state_nxt;
  logic [5:0]        cnt, cnt_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              out_nxt, out_en_nxt, busy_nxt, done_nxt;
`ifdef SEQ_TX_PARITY_EN
  logic              par_q, par_nxt;
`endif

  // in_ready is decoded from the state and is held off while reset is asserted.
  assign in_ready = (state == ST_IDLE) && !rst;

  // Next state, next counter, shift register, and the output values for the following cycle.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    shreg_nxt  = shreg;
`ifdef SEQ_TX_PARITY_EN
    par_nxt    = par_q;
`endif
    out_nxt    = 1'b1;
    out_en_nxt = 1'b0;
    busy_nxt   = 1'b1;
    done_nxt   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt = ST_PRE;
          cnt_nxt   = PRE_TOP;
          shreg_nxt = in_data;
`ifdef SEQ_TX_PARITY_EN
          par_nxt   = ^in_data;
`endif
        end
      end
      ST_PRE: begin
        if (cnt == 6'd0) begin
          state_nxt = ST_DATA;
          cnt_nxt   = DATA_TOP;
        end else begin
          cnt_nxt = cnt - 6'd1;
        end
      end
      ST_DATA: begin
        if (cnt == 6'd0) begin
`ifdef SEQ_TX_PARITY_EN
          state_nxt = ST_PAR;
`else
          state_nxt = (GAP == 0) ? ST_IDLE : ST_GAP;
          cnt_nxt   = GAP_TOP;
`endif
        end else begin
          cnt_nxt = cnt - 6'd1;
        end
      end
`ifdef SEQ_TX_PARITY_EN
      ST_PAR: begin
        state_nxt = (GAP == 0) ? ST_IDLE : ST_GAP;
        cnt_nxt   = GAP_TOP;
      end
`endif
      ST_GAP: begin
        if (cnt == 6'd0) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - 6'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Outputs are computed for the state being entered, so that they are registered alongside it.
    case (state_nxt)
      ST_PRE: begin
        out_nxt    = PRE_PAD[cnt_nxt[2:0]];
        out_en_nxt = 1'b1;
      end
      ST_DATA: begin
        out_nxt    = shreg[DATA_W-1];
        out_en_nxt = 1'b1;
        shreg_nxt  = shreg << 1;
`ifndef SEQ_TX_PARITY_EN
        done_nxt   = (cnt_nxt == 6'd0);
`endif
      end
`ifdef SEQ_TX_PARITY_EN
      ST_PAR: begin
        out_nxt    = par_q;
        out_en_nxt = 1'b1;
        done_nxt   = 1'b1;
      end
`endif
      ST_IDLE: busy_nxt = 1'b0;
      default: ;
    endcase
  end

  // State and output registers. A synchronous reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 6'd0;
      shreg      <= '0;
      out        <= 1'b1;
      out_en     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      shreg      <= shreg_nxt;
      out        <= out_nxt;
      out_en     <= out_en_nxt;
      busy       <= busy_nxt;
      frame_done <= done_nxt;
`ifdef SEQ_TX_PARITY_EN
      par_q      <= par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Testbench for seq_pattern_tx with default parameters: PRE_LEN=4, PREAMBLE=0101, DATA_W=8, GAP=2.
// It covers table-driven frames, hand-written multi-cycle corner cases, and randomized traffic checked against a frame-queue model.
// The parity build is followed through SEQ_TX_PARITY_EN.
module tb_seq_pattern_tx;

  localparam int GAP_C = 2;
`ifdef SEQ_TX_PARITY_EN
  localparam int L = 13;
`else
  localparam int L = 12;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready, out, out_en, busy, frame_done;

  int checks = 0;
  int errors = 0;

  seq_pattern_tx dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out        (out),
    .out_en     (out_en),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic [11:0] bits;  // preamble followed by the data, MSB first
    logic        par;   // expected even parity bit
  } vec_t;
  vec_t tbl[7];

  typedef struct packed {
    logic o;
    logic en;
    logic bz;
    logic dn;
  } rec_t;
  rec_t q[$];
  logic cur_idle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame built from the rules: the preamble, then the data MSB first, then the parity bit if enabled.
  function automatic logic [12:0] fr(input logic [7:0] d);
`ifdef SEQ_TX_PARITY_EN
    return {4'b0101, d, ^d};
`else
    return {1'b0, 4'b0101, d};
`endif
  endfunction

  task automatic push_frame(input logic [7:0] d);
    logic [12:0] f;
    f = fr(d);
    for (int k = 0; k < L; k++)
      q.push_back(rec_t'{f[L-1-k], 1'b1, 1'b1, (k == L-1)});
    for (int g = 0; g < GAP_C; g++)
      q.push_back(rec_t'{1'b1, 1'b0, 1'b1, 1'b0});
  endtask

  // Advance one cycle against the model. The inputs given here apply to the current cycle.
  task automatic tick(input logic v, input logic [7:0] d, input logic r);
    rec_t e;
    in_valid = v; in_data = d; rst = r;
    #1;
    chk("model_in_ready", {31'b0, in_ready}, {31'b0, cur_idle && !r});
    if (r) q.delete();
    else if (cur_idle && v) push_frame(d);
    @(posedge clk); #1;
    cur_idle = (q.size() == 0);
    e = cur_idle ? rec_t'{1'b1, 1'b0, 1'b0, 1'b0} : q.pop_front();
    chk("model_outputs", {28'b0, out, out_en, busy, frame_done}, {28'b0, e});
  endtask

  // Send one word from the idle state and verify the frame, the gap, and the return to idle.
  // in_valid and in_data are scrambled while the frame is in progress.
  task automatic send_and_check(input vec_t v);
    logic [12:0] got, exp;
    int done_at;
    logic en_ok, rdy_low, gap_ok;
`ifdef SEQ_TX_PARITY_EN
    exp = {v.bits, v.par};
`else
    exp = {1'b0, v.bits};
`endif
    in_valid = 1'b1; in_data = v.d;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = ~v.d;
    got = '0; done_at = -1; en_ok = 1'b1; rdy_low = 1'b1;
    for (int k = 0; k < L; k++) begin
      got = {got[11:0], out};
      if (!out_en || !busy) en_ok = 1'b0;
      if (in_ready) rdy_low = 1'b0;
      if (frame_done) done_at = (done_at < 0) ? k : 99;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("frame_bits", {19'b0, got}, {19'b0, exp});
    chk("frame_done_pos", done_at, L - 1);
    chk("frame_out_en_busy", {31'b0, en_ok}, 32'd1);
    chk("frame_ready_low", {31'b0, rdy_low}, 32'd1);
    gap_ok = 1'b1;
    for (int g = 0; g < GAP_C; g++) begin
      if (out !== 1'b1 || out_en !== 1'b0 || busy !== 1'b1 || frame_done !== 1'b0 || in_ready !== 1'b0)
        gap_ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("gap_cycles", {31'b0, gap_ok}, 32'd1);
    chk("idle_after_gap", {29'b0, in_ready, busy, out_en}, 32'b100);
  endtask

  initial begin
    int first_done, second_start, first_rdy, nbits;
    logic [31:0] stream, exp_s;
    logic drop, bad;

    tbl[0] = '{8'hA5, 12'b0101_1010_0101, 1'b0};
    tbl[1] = '{8'h07, 12'b0101_0000_0111, 1'b1};
    tbl[2] = '{8'h3C, 12'b0101_0011_1100, 1'b0};
    tbl[3] = '{8'hFF, 12'b0101_1111_1111, 1'b0};
    tbl[4] = '{8'h00, 12'b0101_0000_0000, 1'b0};
    tbl[5] = '{8'h80, 12'b0101_1000_0000, 1'b1};
    tbl[6] = '{8'h01, 12'b0101_0000_0001, 1'b1};

    // Reset is held for 3 cycles. All outputs must be idle and in_ready must be forced low.
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("reset_outputs", {28'b0, out, out_en, busy, frame_done}, 32'b1000);
      chk("reset_in_ready", {31'b0, in_ready}, 32'd0);
    end
    rst = 1'b0; #1;
    chk("ready_after_reset", {31'b0, in_ready}, 32'd1);

    // Table-driven single frames.
    for (int i = 0; i < 7; i++) send_and_check(tbl[i]);

    // Back-to-back frames with in_valid held high: 3C, then C3.
    in_valid = 1'b1; in_data = 8'h3C;
    @(posedge clk); #1;
    in_data = 8'hC3;
    stream = '0; nbits = 0; first_done = -1; second_start = -1; first_rdy = -1;
    for (int c = 0; c < 40; c++) begin
      drop = 1'b0;
      if (out_en) begin
        stream = {stream[30:0], out};
        nbits++;
        if (nbits == L + 1) second_start = c;
      end
      if (frame_done && first_done < 0) first_done = c;
      if (in_ready && first_rdy < 0) begin first_rdy = c; drop = 1'b1; end
      @(posedge clk); #1;
      if (drop) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    exp_s = ({19'b0, fr(8'h3C)} << L) | {19'b0, fr(8'hC3)};
    chk("b2b_bit_count", nbits, 2 * L);
    chk("b2b_stream", stream, exp_s);
    chk("b2b_first_ready", first_rdy, L + GAP_C);
    chk("b2b_gap_cycles", second_start - first_done - 1, GAP_C + 1);

    // Reset asserted during the 4th data bit of an A5 frame.
    in_valid = 1'b1; in_data = 8'hA5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4 + 3) begin @(posedge clk); #1; end
    chk("abort_4th_data_bit", {30'b0, out, out_en}, 32'b01);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_outputs", {28'b0, out, out_en, busy, frame_done}, 32'b1000);
    chk("abort_ready_in_reset", {31'b0, in_ready}, 32'd0);
    rst = 1'b0; #1;
    chk("abort_ready_after", {31'b0, in_ready}, 32'd1);
    bad = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (out_en || frame_done || busy || !out) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort_stays_idle", {31'b0, bad}, 32'd0);
    send_and_check(tbl[3]);

    // Model-checked traffic. It starts with rst and in_valid in the same cycle, where reset wins.
    cur_idle = 1'b1;
    tick(1'b1, 8'h5A, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 600; i++)
      tick(($urandom_range(0, 9) < 4), 8'($urandom), ($urandom_range(0, 63) == 0));
    rst = 1'b0; in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1);
  end

endmodule
